// File: rtl/wqe_class_cache_if.sv
// wqe_class_cache_if: write, backpressure and read bundle
// between wqe_fetch, the cache and slice_station.
interface wqe_class_cache_if #(
  parameter int WQE_WIDTH    = 512,
  parameter int MAX_QP       = 16,
  parameter int QP_PTR_WIDTH = 4,
  parameter int BS_SLOT_NUM  = 4
);
  localparam int SW =
    (BS_SLOT_NUM > 1) ? $clog2(BS_SLOT_NUM) : 1;

  logic                    i_wqe_cache_wr;
  logic [WQE_WIDTH-1:0]    i_wqe;
  logic [MAX_QP-1:0]       o_wqe_cache_alfull;
  logic [MAX_QP-1:0]       o_wqe_cache_full;
  logic                    o_wqe_cache_wr_val;
  logic [QP_PTR_WIDTH-1:0] o_wqe_cache_wr_qpn;
  logic [63:0]             o_wqe_cache_wr_wrid;
  logic                    o_wqe_drop;
  logic [15:0]             o_drop_cnt;
  logic                    o_ls_wqe_empty;
  logic                    i_ls_wqe_ren;
  logic                    o_ls_wqe_val;
  logic [WQE_WIDTH-1:0]    o_ls_wqe_rdata;
  logic [BS_SLOT_NUM-1:0]  o_bs_fifo_empty;
  logic [BS_SLOT_NUM-1:0]  i_bs_fifo_rd;
  logic                    o_bs_wqe_val;
  logic [WQE_WIDTH-1:0]    o_bs_wqe;
  logic [SW-1:0]           o_bs_wqe_slot;
  logic                    o_bs_rd_err;

  modport slave (
    input  i_wqe_cache_wr, i_wqe,
    input  i_ls_wqe_ren, i_bs_fifo_rd,
    output o_wqe_cache_alfull, o_wqe_cache_full,
    output o_wqe_cache_wr_val, o_wqe_cache_wr_qpn,
    output o_wqe_cache_wr_wrid,
    output o_wqe_drop, o_drop_cnt,
    output o_ls_wqe_empty, o_ls_wqe_val,
    output o_ls_wqe_rdata,
    output o_bs_fifo_empty, o_bs_wqe_val,
    output o_bs_wqe, o_bs_wqe_slot, o_bs_rd_err
  );

  modport master (
    output i_wqe_cache_wr, i_wqe,
    output i_ls_wqe_ren, i_bs_fifo_rd,
    input  o_wqe_cache_alfull, o_wqe_cache_full,
    input  o_wqe_cache_wr_val, o_wqe_cache_wr_qpn,
    input  o_wqe_cache_wr_wrid,
    input  o_wqe_drop, o_drop_cnt,
    input  o_ls_wqe_empty, o_ls_wqe_val,
    input  o_ls_wqe_rdata,
    input  o_bs_fifo_empty, o_bs_wqe_val,
    input  o_bs_wqe, o_bs_wqe_slot, o_bs_rd_err
  );
endinterface

// File: rtl/wqe_class_cache.sv
// wqe_class_cache: QPN-classified WQE cache with one LS FIFO,
// per-slot BS FIFOs, per-QP backpressure and drop accounting.
module wqe_class_cache #(
  parameter int WQE_WIDTH     = 512,
  parameter int MAX_QP        = 16,
  parameter int QP_PTR_WIDTH  = 4,
  parameter int QPID_LSB      = 328,
  parameter int BS_SLOT_NUM   = 4,
  parameter int DEPTH_LOG2    = 4,
  parameter int ALFULL_MARGIN = 1
) (
  input logic              clk,
  input logic              rst_n,
  wqe_class_cache_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int SW    =
    (BS_SLOT_NUM > 1) ? $clog2(BS_SLOT_NUM) : 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   =
    CW'(DEPTH - ALFULL_MARGIN);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [WQE_WIDTH-1:0]  wqe_t;

  wqe_t ls_mem [DEPTH];
  wqe_t bs_mem [BS_SLOT_NUM][DEPTH];

  ptr_t ls_wptr, ls_rptr;
  cnt_t ls_cnt;
  ptr_t bs_wptr [BS_SLOT_NUM];
  ptr_t bs_rptr [BS_SLOT_NUM];
  cnt_t bs_cnt  [BS_SLOT_NUM];

  logic ls_full, ls_alfull, ls_empty;
  logic [BS_SLOT_NUM-1:0] bs_full, bs_alfull, bs_empty;

  logic [QP_PTR_WIDTH-1:0] qpn;
  logic [31:0]             slot;
  logic to_ls, to_bs, tgt_full, wr_ok, drop;
  logic ls_push, ls_pop, bs_onehot, bs_multi;
  logic [BS_SLOT_NUM-1:0] bs_push, bs_pop;

  assign qpn   = bus.i_wqe[QPID_LSB +: QP_PTR_WIDTH];
  assign slot  = 32'(qpn >> 1);
  assign to_ls = ~qpn[0];
  assign to_bs = qpn[0] & (slot < 32'(BS_SLOT_NUM));

  always_comb begin
    tgt_full = ls_full;
    for (int k = 0; k < BS_SLOT_NUM; k++)
      if (to_bs && slot == 32'(k))
        tgt_full = bs_full[k];
    wr_ok = bus.i_wqe_cache_wr & (to_ls | to_bs)
          & ~tgt_full;
    ls_push = wr_ok & to_ls;
    bs_push = '0;
    for (int k = 0; k < BS_SLOT_NUM; k++)
      bs_push[k] = wr_ok & to_bs & (slot == 32'(k));
  end

  assign drop      = bus.i_wqe_cache_wr & ~wr_ok;
  assign ls_pop    = bus.i_ls_wqe_ren & ~ls_empty;
  assign bs_onehot = $onehot(bus.i_bs_fifo_rd);
  assign bs_multi  = (bus.i_bs_fifo_rd != '0) & ~bs_onehot;
  assign bs_pop    = bs_onehot
                   ? (bus.i_bs_fifo_rd & ~bs_empty) : '0;

  assign ls_full   = ls_cnt == FULL_LVL;
  assign ls_alfull = ls_cnt >= AF_LVL;
  assign ls_empty  = ls_cnt == '0;

  for (genvar k = 0; k < BS_SLOT_NUM; k++) begin : g_bsf
    assign bs_full[k]   = bs_cnt[k] == FULL_LVL;
    assign bs_alfull[k] = bs_cnt[k] >= AF_LVL;
    assign bs_empty[k]  = bs_cnt[k] == '0;
  end

  // Odd QPNs beyond the last slot have no storage: report them
  // permanently full so upstream never targets them.
  for (genvar i = 0; i < MAX_QP; i++) begin : g_bp
    if (i % 2 == 0) begin : g_ls
      assign bus.o_wqe_cache_full[i]   = ls_full;
      assign bus.o_wqe_cache_alfull[i] = ls_alfull;
    end else if ((i >> 1) < BS_SLOT_NUM) begin : g_bs
      assign bus.o_wqe_cache_full[i]   = bs_full[i>>1];
      assign bus.o_wqe_cache_alfull[i] = bs_alfull[i>>1];
    end else begin : g_un
      assign bus.o_wqe_cache_full[i]   = 1'b1;
      assign bus.o_wqe_cache_alfull[i] = 1'b1;
    end
  end

  assign bus.o_wqe_cache_wr_val  = wr_ok;
  assign bus.o_wqe_cache_wr_qpn  = qpn;
  assign bus.o_wqe_cache_wr_wrid = bus.i_wqe[63:0];
  assign bus.o_ls_wqe_empty      = ls_empty;
  assign bus.o_bs_fifo_empty     = bs_empty;

  always_ff @(posedge clk) begin
    if (ls_push) ls_mem[ls_wptr] <= bus.i_wqe;
    for (int k = 0; k < BS_SLOT_NUM; k++)
      if (bs_push[k]) bs_mem[k][bs_wptr[k]] <= bus.i_wqe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_wptr <= '0;
      ls_rptr <= '0;
      ls_cnt  <= '0;
      for (int k = 0; k < BS_SLOT_NUM; k++) begin
        bs_wptr[k] <= '0;
        bs_rptr[k] <= '0;
        bs_cnt[k]  <= '0;
      end
    end else begin
      if (ls_push) ls_wptr <= ls_wptr + 1'b1;
      if (ls_pop)  ls_rptr <= ls_rptr + 1'b1;
      if (ls_push && !ls_pop)
        ls_cnt <= ls_cnt + 1'b1;
      else if (ls_pop && !ls_push)
        ls_cnt <= ls_cnt - 1'b1;
      for (int k = 0; k < BS_SLOT_NUM; k++) begin
        if (bs_push[k]) bs_wptr[k] <= bs_wptr[k] + 1'b1;
        if (bs_pop[k])  bs_rptr[k] <= bs_rptr[k] + 1'b1;
        if (bs_push[k] && !bs_pop[k])
          bs_cnt[k] <= bs_cnt[k] + 1'b1;
        else if (bs_pop[k] && !bs_push[k])
          bs_cnt[k] <= bs_cnt[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_ls_wqe_val   <= 1'b0;
      bus.o_ls_wqe_rdata <= '0;
      bus.o_bs_wqe_val   <= 1'b0;
      bus.o_bs_wqe       <= '0;
      bus.o_bs_wqe_slot  <= '0;
      bus.o_bs_rd_err    <= 1'b0;
      bus.o_wqe_drop     <= 1'b0;
      bus.o_drop_cnt     <= '0;
    end else begin
      bus.o_ls_wqe_val <= ls_pop;
      if (ls_pop)
        bus.o_ls_wqe_rdata <= ls_mem[ls_rptr];
      bus.o_bs_wqe_val <= |bs_pop;
      bus.o_bs_rd_err  <= bs_multi;
      for (int k = 0; k < BS_SLOT_NUM; k++)
        if (bs_pop[k]) begin
          bus.o_bs_wqe      <= bs_mem[k][bs_rptr[k]];
          bus.o_bs_wqe_slot <= SW'(k);
        end
      bus.o_wqe_drop <= drop;
      if (drop && bus.o_drop_cnt != 16'hFFFF)
        bus.o_drop_cnt <= bus.o_drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wqe_class_cache.sv
// tb_wqe_class_cache: directed and random stimulus checked
// against a queue-based model of the classified cache.
module tb_wqe_class_cache;
  localparam int W     = 512;
  localparam int NQ    = 16;
  localparam int QW    = 4;
  localparam int QL    = 328;
  localparam int NS    = 4;
  localparam int DL    = 4;
  localparam int AM    = 1;
  localparam int DEPTH = 16;

  typedef logic [W-1:0] wqe_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wqe_class_cache_if #(
    .WQE_WIDTH(W), .MAX_QP(NQ),
    .QP_PTR_WIDTH(QW), .BS_SLOT_NUM(NS)
  ) bus ();

  wqe_class_cache #(
    .WQE_WIDTH(W), .MAX_QP(NQ), .QP_PTR_WIDTH(QW),
    .QPID_LSB(QL), .BS_SLOT_NUM(NS),
    .DEPTH_LOG2(DL), .ALFULL_MARGIN(AM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  wqe_t ls_q[$];
  wqe_t bs_q[NS][$];
  int   drop_cnt;
  wqe_t ls_data;
  int   n_chk;
  int   n_pass;

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Occupancy of the queue a QPN maps to, -1 when unmapped.
  function automatic int tgt_size(int q);
    if (q % 2 == 0) return ls_q.size();
    if ((q >> 1) < NS) return bs_q[q>>1].size();
    return -1;
  endfunction

  function automatic wqe_t mk_wqe(int q, logic [63:0] wrid);
    wqe_t w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    w[63:0]    = wrid;
    w[QL +: QW] = q[QW-1:0];
    return w;
  endfunction

  task automatic chk_flags();
    logic [NQ-1:0] ef, ea;
    logic [NS-1:0] be;
    int s;
    for (int i = 0; i < NQ; i++) begin
      s = tgt_size(i);
      ef[i] = (s < 0) || (s == DEPTH);
      ea[i] = (s < 0) || (s >= DEPTH - AM);
    end
    for (int k = 0; k < NS; k++) be[k] = bs_q[k].size() == 0;
    chk("full", bus.o_wqe_cache_full, ef);
    chk("alfull", bus.o_wqe_cache_alfull, ea);
    chk("ls_empty", bus.o_ls_wqe_empty, ls_q.size() == 0);
    chk("bs_empty", bus.o_bs_fifo_empty, be);
  endtask

  task automatic chk_reset();
    chk("rst_ls_val", bus.o_ls_wqe_val, '0);
    chk("rst_ls_rdata", bus.o_ls_wqe_rdata, '0);
    chk("rst_bs_val", bus.o_bs_wqe_val, '0);
    chk("rst_bs_wqe", bus.o_bs_wqe, '0);
    chk("rst_bs_slot", bus.o_bs_wqe_slot, '0);
    chk("rst_rd_err", bus.o_bs_rd_err, '0);
    chk("rst_drop", bus.o_wqe_drop, '0);
    chk("rst_drop_cnt", bus.o_drop_cnt, '0);
    chk_flags();
  endtask

  task automatic idle();
    bus.i_wqe_cache_wr = 1'b0;
    bus.i_ls_wqe_ren   = 1'b0;
    bus.i_bs_fifo_rd   = '0;
  endtask

  task automatic model_clear();
    ls_q.delete();
    for (int k = 0; k < NS; k++) bs_q[k].delete();
    drop_cnt = 0;
    ls_data  = '0;
  endtask

  // One clock: drive, check combinational write status, advance
  // the model, then check every registered output.
  task automatic cycle(bit wr, int q, logic [63:0] wrid,
                       bit ren, logic [NS-1:0] rd);
    wqe_t w;
    wqe_t bs_data;
    int s, bs_slot;
    bit acc, drop, lsp, bsp, err;
    w = mk_wqe(q, wrid);
    bus.i_wqe_cache_wr = wr;
    bus.i_wqe          = w;
    bus.i_ls_wqe_ren   = ren;
    bus.i_bs_fifo_rd   = rd;
    s    = tgt_size(q);
    acc  = wr && s >= 0 && s < DEPTH;
    drop = wr && !acc;
    #1;
    chk("wr_val", bus.o_wqe_cache_wr_val, acc);
    chk("wr_qpn", bus.o_wqe_cache_wr_qpn, q[QW-1:0]);
    chk("wr_wrid", bus.o_wqe_cache_wr_wrid, wrid);
    lsp = ren && ls_q.size() > 0;
    if (lsp) ls_data = ls_q.pop_front();
    bsp = 1'b0;
    bs_slot = 0;
    bs_data = '0;
    err = $countones(rd) > 1;
    if ($countones(rd) == 1)
      for (int k = 0; k < NS; k++)
        if (rd[k] && bs_q[k].size() > 0) begin
          bs_data = bs_q[k].pop_front();
          bs_slot = k;
          bsp = 1'b1;
        end
    if (acc) begin
      if (q % 2 == 0) ls_q.push_back(w);
      else bs_q[q>>1].push_back(w);
    end
    if (drop && drop_cnt < 65535) drop_cnt++;
    @(posedge clk);
    #1;
    chk("ls_val", bus.o_ls_wqe_val, lsp);
    chk("ls_rdata", bus.o_ls_wqe_rdata, ls_data);
    chk("bs_val", bus.o_bs_wqe_val, bsp);
    if (bsp) begin
      chk("bs_wqe", bus.o_bs_wqe, bs_data);
      chk("bs_slot", bus.o_bs_wqe_slot, bs_slot);
    end
    chk("rd_err", bus.o_bs_rd_err, err);
    chk("drop", bus.o_wqe_drop, drop);
    chk("drop_cnt", bus.o_drop_cnt, drop_cnt);
    chk_flags();
    idle();
  endtask

  initial begin
    int r;
    logic [NS-1:0] rd;
    n_chk  = 0;
    n_pass = 0;
    model_clear();
    bus.i_wqe = '0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    cycle(1, 0, 64'h11, 0, '0);
    cycle(0, 0, 64'h0, 1, '0);

    for (int i = 0; i < 16; i++) cycle(1, 3, 64'(i + 32'h300), 0, '0);
    cycle(1, 3, 64'h399, 0, '0);
    cycle(1, 9, 64'h900, 0, '0);

    cycle(1, 1, 64'h100, 0, '0);
    cycle(1, 5, 64'h500, 0, '0);
    cycle(0, 0, 64'h0, 0, 4'b0101);
    cycle(0, 0, 64'h0, 0, 4'b0100);

    cycle(1, 3, 64'h3AA, 0, 4'b0010);
    cycle(1, 0, 64'h22, 1, '0);

    for (int i = 0; i < 4; i++) cycle(1, 2 * i, 64'(i + 32'h40), 0, '0);
    bus.i_wqe_cache_wr = 1'b1;
    bus.i_wqe = mk_wqe(0, 64'h55);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_reset();
    @(posedge clk);
    #1;
    chk_reset();
    idle();
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) rd = '0;
      else if (r < 9) rd = NS'(1) << $urandom_range(0, NS - 1);
      else rd = NS'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15),
            {$urandom, $urandom}, $urandom_range(0, 2) == 0, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
